// File: rtl/sprite_drawer_if.sv
// Pixel-write and control bundle between a sprite_drawer, its frame scheduler
// and the VGA adapter. master = scheduler/bench side, slave = drawer.
interface sprite_drawer_if #(
  parameter int SIZE = 5
);
  logic                   start;
  logic [SIZE*SIZE-1:0]   shape;
  logic [7:0]             x_in;
  logic [6:0]             y_in;
  logic [2:0]             colour;
  logic [2:0]             bg_colour;
  logic [7:0]             vga_x;
  logic [6:0]             vga_y;
  logic [2:0]             vga_colour;
  logic                   plot;
  logic                   busy;
  logic                   done;

  modport master (
    output start, shape, x_in, y_in, colour, bg_colour,
    input  vga_x, vga_y, vga_colour, plot, busy, done
  );

  modport slave (
    input  start, shape, x_in, y_in, colour, bg_colour,
    output vga_x, vga_y, vga_colour, plot, busy, done
  );
endinterface

// File: rtl/sprite_drawer.sv
// Erases a SIZExSIZE sprite at its last drawn position, then draws it at the
// newly requested position, one cell per clock, into the VGA pixel-write port.
module sprite_drawer #(
  parameter int SIZE     = 5,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic           clk,
  input  logic           reset,
  sprite_drawer_if.slave bus
);
  // state | meaning
  // IDLE  | waiting for start; adapter outputs hold, plot low
  // ERASE | repaint previous sprite cells with bg_colour
  // DRAW  | paint latched sprite at latched position
  // DONE  | one-cycle completion pulse
  localparam int N  = SIZE * SIZE;
  localparam int CW = $clog2(N);
  localparam int RW = $clog2(SIZE);
  localparam logic [CW-1:0] LAST_CELL = CW'(N - 1);
  localparam logic [RW-1:0] LAST_COL  = RW'(SIZE - 1);

  typedef enum logic [1:0] {S_IDLE, S_ERASE, S_DRAW, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] row_q, row_d, col_q, col_d;
  logic [N-1:0]  new_shape_q, new_shape_d, old_shape_q, old_shape_d;
  logic [7:0]    new_x_q, new_x_d, old_x_q, old_x_d;
  logic [6:0]    new_y_q, new_y_d, old_y_q, old_y_d;
  logic [2:0]    new_colour_q, new_colour_d;
  logic          old_valid_q, old_valid_d;
  logic [7:0]    vga_x_q, vga_x_d;
  logic [6:0]    vga_y_q, vga_y_d;
  logic [2:0]    vga_colour_q, vga_colour_d;
  logic          plot_q, plot_d, busy_q, busy_d, done_q, done_d;

  logic [N-1:0]  cur_shape;
  logic [7:0]    cur_x;
  logic [6:0]    cur_y;
  logic [8:0]    sum_x;
  logic [7:0]    sum_y;
  logic          active, erasing, cell_on;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    row_d        = row_q;
    col_d        = col_q;
    new_shape_d  = new_shape_q;
    new_x_d      = new_x_q;
    new_y_d      = new_y_q;
    new_colour_d = new_colour_q;
    old_shape_d  = old_shape_q;
    old_x_d      = old_x_q;
    old_y_d      = old_y_q;
    old_valid_d  = old_valid_q;
    vga_x_d      = vga_x_q;
    vga_y_d      = vga_y_q;
    vga_colour_d = vga_colour_q;

    erasing   = (state_q == S_ERASE);
    active    = erasing || (state_q == S_DRAW);
    cur_shape = erasing ? old_shape_q : new_shape_q;
    cur_x     = erasing ? old_x_q     : new_x_q;
    cur_y     = erasing ? old_y_q     : new_y_q;
    // Widened sums so sprites near the right/bottom edge clip instead of wrapping.
    sum_x     = {1'b0, cur_x} + 9'(col_q);
    sum_y     = {1'b0, cur_y} + 8'(row_q);
    cell_on   = cur_shape[LAST_CELL - cnt_q];

    plot_d = active && cell_on && (sum_x < 9'(SCREEN_W)) && (sum_y < 8'(SCREEN_H));
    busy_d = (state_q != S_IDLE);
    done_d = (state_q == S_DONE);

    if (active) begin
      vga_x_d      = sum_x[7:0];
      vga_y_d      = sum_y[6:0];
      vga_colour_d = erasing ? bus.bg_colour : new_colour_q;
    end

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          new_shape_d  = bus.shape;
          new_x_d      = bus.x_in;
          new_y_d      = bus.y_in;
          new_colour_d = bus.colour;
          state_d      = old_valid_q ? S_ERASE : S_DRAW;
        end
      end
      S_ERASE, S_DRAW: begin
        if (cnt_q == LAST_CELL) begin
          cnt_d = '0;
          row_d = '0;
          col_d = '0;
          if (erasing) begin
            state_d = S_DRAW;
          end else begin
            state_d     = S_DONE;
            old_shape_d = new_shape_q;
            old_x_d     = new_x_q;
            old_y_d     = new_y_q;
            old_valid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (col_q == LAST_COL) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      row_q        <= '0;
      col_q        <= '0;
      new_shape_q  <= '0;
      new_x_q      <= '0;
      new_y_q      <= '0;
      new_colour_q <= '0;
      old_shape_q  <= '0;
      old_x_q      <= '0;
      old_y_q      <= '0;
      old_valid_q  <= 1'b0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      plot_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      row_q        <= row_d;
      col_q        <= col_d;
      new_shape_q  <= new_shape_d;
      new_x_q      <= new_x_d;
      new_y_q      <= new_y_d;
      new_colour_q <= new_colour_d;
      old_shape_q  <= old_shape_d;
      old_x_q      <= old_x_d;
      old_y_q      <= old_y_d;
      old_valid_q  <= old_valid_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      plot_q       <= plot_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus.vga_x      = vga_x_q;
  assign bus.vga_y      = vga_y_q;
  assign bus.vga_colour = vga_colour_q;
  assign bus.plot       = plot_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
endmodule

// File: tb/tb_sprite_drawer.sv
// Directed bench for sprite_drawer: per-cycle capture after each start,
// compared against a cell-by-cell expectation built from the request values.
module tb_sprite_drawer;
  localparam int SIZE = 5;
  localparam logic [2:0] BG = 3'b010;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sprite_drawer_if #(.SIZE(SIZE)) bus();
  sprite_drawer #(.SIZE(SIZE), .SCREEN_W(160), .SCREEN_H(120)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );

  int tests_run = 0;
  int tests_failed = 0;
  logic [24:0] shp_a = 25'b1111110101101011111110101;
  logic [24:0] ones  = 25'h1ffffff;

  logic       cap_plot[0:63], cap_busy[0:63], cap_done[0:63];
  logic [7:0] cap_x[0:63];
  logic [6:0] cap_y[0:63];
  logic [2:0] cap_col[0:63];
  logic       exp_plot[0:63], exp_busy[0:63], exp_done[0:63], exp_chk[0:63];
  logic [7:0] exp_x[0:63];
  logic [6:0] exp_y[0:63];
  logic [2:0] exp_col[0:63];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_clear();
    for (int n = 0; n < 64; n++) begin
      exp_plot[n] = 1'b0; exp_busy[n] = 1'b0; exp_done[n] = 1'b0; exp_chk[n] = 1'b0;
      exp_x[n] = '0; exp_y[n] = '0; exp_col[n] = '0;
    end
  endtask

  task automatic model_phase(input int n0, input logic [24:0] shp, input int x, input int y,
                             input logic [2:0] col);
    for (int k = 0; k < 25; k++) begin
      int px, py;
      px = x + k % 5;
      py = y + k / 5;
      exp_chk[n0+k]  = 1'b1;
      exp_x[n0+k]    = 8'(px);
      exp_y[n0+k]    = 7'(py);
      exp_col[n0+k]  = col;
      exp_plot[n0+k] = shp[24-k] && (px < 160) && (py < 120);
    end
  endtask

  task automatic model_ctl(input int busy_end, input int done_at);
    for (int n = 0; n < 64; n++) begin
      exp_busy[n] = (n >= 1) && (n <= busy_end);
      exp_done[n] = (n == done_at);
    end
  endtask

  // Pulses start so edge E0 samples it, then records outputs #1 after E0..E0+ncyc.
  task automatic run(input logic [24:0] shp, input int x, input int y, input logic [2:0] col,
                     input int ncyc, input int restart_at, input int reset_at, input bit toggle);
    @(negedge clk);
    bus.start = 1'b1; bus.shape = shp; bus.x_in = 8'(x); bus.y_in = 7'(y); bus.colour = col;
    @(posedge clk); #1;
    for (int n = 0; n <= ncyc; n++) begin
      if (n > 0) begin @(posedge clk); #1; end
      cap_plot[n] = bus.plot; cap_busy[n] = bus.busy; cap_done[n] = bus.done;
      cap_x[n] = bus.vga_x; cap_y[n] = bus.vga_y; cap_col[n] = bus.vga_colour;
      bus.start = (n == restart_at - 1);
      reset = (n == reset_at - 1);
      if (toggle) begin
        bus.shape = 25'($urandom); bus.x_in = 8'($urandom);
        bus.y_in = 7'($urandom); bus.colour = 3'($urandom);
      end
    end
    bus.start = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    bus.start = 1'b1; bus.shape = '0; bus.x_in = '0; bus.y_in = '0;
    bus.colour = '0; bus.bg_colour = BG;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (bus.plot !== 1'b0) begin tests_failed++; $display("FAIL reset_plot: got %b want 0", bus.plot); end
    tests_run++;
    if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    tests_run++;
    if (bus.done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b want 0", bus.done); end
    tests_run++;
    if ({bus.vga_x, bus.vga_y, bus.vga_colour} !== 18'd0) begin
      tests_failed++;
      $display("FAIL reset_xyc: got (%0d,%0d,%b) want (0,0,000)", bus.vga_x, bus.vga_y, bus.vga_colour);
    end
    reset = 1'b0;
    bus.start = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_wins_over_start: busy got %b want 0", bus.busy); end
  endtask

  task automatic test_first_draw();
    int cnt;
    model_clear();
    model_phase(1, shp_a, 27, 24, 3'b100);
    model_ctl(26, 26);
    run(shp_a, 27, 24, 3'b100, 30, -1, -1, 1'b0);
    for (int n = 0; n <= 30; n++) begin
      tests_run++;
      if ({cap_plot[n], cap_busy[n], cap_done[n]} !== {exp_plot[n], exp_busy[n], exp_done[n]} ||
          (exp_chk[n] && {cap_x[n], cap_y[n], cap_col[n]} !== {exp_x[n], exp_y[n], exp_col[n]})) begin
        tests_failed++;
        $display("FAIL first_draw cyc %0d: got pbd=%b%b%b (%0d,%0d) c=%b, want pbd=%b%b%b (%0d,%0d) c=%b",
                 n, cap_plot[n], cap_busy[n], cap_done[n], cap_x[n], cap_y[n], cap_col[n],
                 exp_plot[n], exp_busy[n], exp_done[n], exp_x[n], exp_y[n], exp_col[n]);
      end
    end
    cnt = 0;
    for (int n = 0; n <= 30; n++) if (cap_plot[n] === 1'b1) cnt++;
    tests_run++;
    if (cnt != 19) begin tests_failed++; $display("FAIL first_draw_count: got %0d want 19", cnt); end
    tests_run++;
    if ({cap_plot[1], cap_x[1], cap_y[1], cap_col[1]} !== {1'b1, 8'd27, 7'd24, 3'b100}) begin
      tests_failed++;
      $display("FAIL first_pulse: got p=%b (%0d,%0d) c=%b want p=1 (27,24) c=100",
               cap_plot[1], cap_x[1], cap_y[1], cap_col[1]);
    end
    cnt = 0;
    for (int n = 0; n <= 30; n++) if (cap_plot[n] === 1'b1 && cap_x[n] == 8'd28 && cap_y[n] == 7'd25) cnt++;
    tests_run++;
    if (cnt != 0) begin tests_failed++; $display("FAIL hole_28_25: got %0d pulses want 0", cnt); end
  endtask

  task automatic test_redraw_move();
    model_clear();
    model_phase(1, shp_a, 27, 24, BG);
    model_phase(26, shp_a, 28, 24, 3'b100);
    model_ctl(51, 51);
    run(shp_a, 28, 24, 3'b100, 55, -1, -1, 1'b0);
    for (int n = 0; n <= 55; n++) begin
      tests_run++;
      if ({cap_plot[n], cap_busy[n], cap_done[n]} !== {exp_plot[n], exp_busy[n], exp_done[n]} ||
          (exp_chk[n] && {cap_x[n], cap_y[n], cap_col[n]} !== {exp_x[n], exp_y[n], exp_col[n]})) begin
        tests_failed++;
        $display("FAIL redraw_move cyc %0d: got pbd=%b%b%b (%0d,%0d) c=%b, want pbd=%b%b%b (%0d,%0d) c=%b",
                 n, cap_plot[n], cap_busy[n], cap_done[n], cap_x[n], cap_y[n], cap_col[n],
                 exp_plot[n], exp_busy[n], exp_done[n], exp_x[n], exp_y[n], exp_col[n]);
      end
    end
  endtask

  task automatic test_clip();
    int cnt, bad;
    model_clear();
    model_phase(1, shp_a, 28, 24, BG);
    model_phase(26, ones, 157, 117, 3'b111);
    model_ctl(51, 51);
    run(ones, 157, 117, 3'b111, 55, -1, -1, 1'b0);
    for (int n = 0; n <= 55; n++) begin
      tests_run++;
      if ({cap_plot[n], cap_busy[n], cap_done[n]} !== {exp_plot[n], exp_busy[n], exp_done[n]} ||
          (exp_chk[n] && {cap_x[n], cap_y[n], cap_col[n]} !== {exp_x[n], exp_y[n], exp_col[n]})) begin
        tests_failed++;
        $display("FAIL clip cyc %0d: got pbd=%b%b%b (%0d,%0d) c=%b, want pbd=%b%b%b (%0d,%0d) c=%b",
                 n, cap_plot[n], cap_busy[n], cap_done[n], cap_x[n], cap_y[n], cap_col[n],
                 exp_plot[n], exp_busy[n], exp_done[n], exp_x[n], exp_y[n], exp_col[n]);
      end
    end
    cnt = 0; bad = 0;
    for (int n = 26; n <= 55; n++) begin
      if (cap_plot[n] === 1'b1) cnt++;
      if (cap_plot[n] === 1'b1 && (cap_x[n] >= 8'd160 || cap_y[n] >= 7'd120)) bad++;
    end
    tests_run++;
    if (cnt != 9) begin tests_failed++; $display("FAIL clip_count: got %0d want 9", cnt); end
    tests_run++;
    if (bad != 0) begin tests_failed++; $display("FAIL clip_offscreen: got %0d pulses want 0", bad); end
  endtask

  task automatic test_start_ignored();
    model_clear();
    model_phase(1, ones, 157, 117, BG);
    model_phase(26, shp_a, 10, 10, 3'b001);
    model_ctl(51, 51);
    run(shp_a, 10, 10, 3'b001, 55, 10, -1, 1'b0);
    for (int n = 0; n <= 55; n++) begin
      tests_run++;
      if ({cap_plot[n], cap_busy[n], cap_done[n]} !== {exp_plot[n], exp_busy[n], exp_done[n]} ||
          (exp_chk[n] && {cap_x[n], cap_y[n], cap_col[n]} !== {exp_x[n], exp_y[n], exp_col[n]})) begin
        tests_failed++;
        $display("FAIL start_ignored cyc %0d: got pbd=%b%b%b (%0d,%0d) c=%b, want pbd=%b%b%b (%0d,%0d) c=%b",
                 n, cap_plot[n], cap_busy[n], cap_done[n], cap_x[n], cap_y[n], cap_col[n],
                 exp_plot[n], exp_busy[n], exp_done[n], exp_x[n], exp_y[n], exp_col[n]);
      end
    end
  endtask

  task automatic test_reset_abort();
    model_clear();
    model_phase(1, shp_a, 10, 10, BG);
    model_phase(26, ones, 50, 60, 3'b110);
    model_ctl(29, -1);
    for (int n = 30; n <= 40; n++) begin
      exp_plot[n] = 1'b0; exp_chk[n] = 1'b1; exp_x[n] = '0; exp_y[n] = '0; exp_col[n] = '0;
    end
    run(ones, 50, 60, 3'b110, 40, -1, 30, 1'b0);
    for (int n = 0; n <= 40; n++) begin
      tests_run++;
      if ({cap_plot[n], cap_busy[n], cap_done[n]} !== {exp_plot[n], exp_busy[n], exp_done[n]} ||
          (exp_chk[n] && {cap_x[n], cap_y[n], cap_col[n]} !== {exp_x[n], exp_y[n], exp_col[n]})) begin
        tests_failed++;
        $display("FAIL reset_abort cyc %0d: got pbd=%b%b%b (%0d,%0d) c=%b, want pbd=%b%b%b (%0d,%0d) c=%b",
                 n, cap_plot[n], cap_busy[n], cap_done[n], cap_x[n], cap_y[n], cap_col[n],
                 exp_plot[n], exp_busy[n], exp_done[n], exp_x[n], exp_y[n], exp_col[n]);
      end
    end
    model_clear();
    model_phase(1, shp_a, 50, 60, 3'b110);
    model_ctl(26, 26);
    run(shp_a, 50, 60, 3'b110, 30, -1, -1, 1'b0);
    for (int n = 0; n <= 30; n++) begin
      tests_run++;
      if ({cap_plot[n], cap_busy[n], cap_done[n]} !== {exp_plot[n], exp_busy[n], exp_done[n]} ||
          (exp_chk[n] && {cap_x[n], cap_y[n], cap_col[n]} !== {exp_x[n], exp_y[n], exp_col[n]})) begin
        tests_failed++;
        $display("FAIL after_reset_no_erase cyc %0d: got pbd=%b%b%b (%0d,%0d) c=%b, want pbd=%b%b%b (%0d,%0d) c=%b",
                 n, cap_plot[n], cap_busy[n], cap_done[n], cap_x[n], cap_y[n], cap_col[n],
                 exp_plot[n], exp_busy[n], exp_done[n], exp_x[n], exp_y[n], exp_col[n]);
      end
    end
  endtask

  task automatic test_input_toggle();
    model_clear();
    model_phase(1, shp_a, 50, 60, BG);
    model_phase(26, shp_a, 100, 30, 3'b011);
    model_ctl(51, 51);
    run(shp_a, 100, 30, 3'b011, 55, -1, -1, 1'b1);
    for (int n = 0; n <= 55; n++) begin
      tests_run++;
      if ({cap_plot[n], cap_busy[n], cap_done[n]} !== {exp_plot[n], exp_busy[n], exp_done[n]} ||
          (exp_chk[n] && {cap_x[n], cap_y[n], cap_col[n]} !== {exp_x[n], exp_y[n], exp_col[n]})) begin
        tests_failed++;
        $display("FAIL input_toggle cyc %0d: got pbd=%b%b%b (%0d,%0d) c=%b, want pbd=%b%b%b (%0d,%0d) c=%b",
                 n, cap_plot[n], cap_busy[n], cap_done[n], cap_x[n], cap_y[n], cap_col[n],
                 exp_plot[n], exp_busy[n], exp_done[n], exp_x[n], exp_y[n], exp_col[n]);
      end
    end
  endtask

  task automatic test_same_position();
    model_clear();
    model_phase(1, shp_a, 100, 30, BG);
    model_phase(26, shp_a, 100, 30, 3'b011);
    model_ctl(51, 51);
    run(shp_a, 100, 30, 3'b011, 55, -1, -1, 1'b0);
    for (int n = 0; n <= 55; n++) begin
      tests_run++;
      if ({cap_plot[n], cap_busy[n], cap_done[n]} !== {exp_plot[n], exp_busy[n], exp_done[n]} ||
          (exp_chk[n] && {cap_x[n], cap_y[n], cap_col[n]} !== {exp_x[n], exp_y[n], exp_col[n]})) begin
        tests_failed++;
        $display("FAIL same_position cyc %0d: got pbd=%b%b%b (%0d,%0d) c=%b, want pbd=%b%b%b (%0d,%0d) c=%b",
                 n, cap_plot[n], cap_busy[n], cap_done[n], cap_x[n], cap_y[n], cap_col[n],
                 exp_plot[n], exp_busy[n], exp_done[n], exp_x[n], exp_y[n], exp_col[n]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_draw();
    test_redraw_move();
    test_clip();
    test_start_ignored();
    test_reset_abort();
    test_input_toggle();
    test_same_position();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
